// File: rtl/exec_controller_pkg.sv
// exec_ctrl_pkg: scheduler states and shared constants for exec_controller
package exec_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RUN, STEP, WAIT_INPUT, HALTED} exec_state_t;
  localparam logic [31:0] DIVISOR_DEFAULT = 32'd50_000_000;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/exec_controller_if.sv
// exec_controller_if: user/core requests in, enable pulses and status out
// Pc/BpAddr exist only when EXEC_CTRL_BREAKPOINT_EN is defined
interface exec_controller_if;
  logic Play, Step, InputAck, InputReq, HaltReq;
  logic CpuEn, InputLatch, Running, Waiting, Halted;
  logic [31:0] InstrCount;
`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic [31:0] Pc, BpAddr;
  modport master(output Play, Step, InputAck, InputReq, HaltReq, Pc, BpAddr,
                 input CpuEn, InputLatch, Running, Waiting, Halted, InstrCount);
  modport slave(input Play, Step, InputAck, InputReq, HaltReq, Pc, BpAddr,
                output CpuEn, InputLatch, Running, Waiting, Halted, InstrCount);
`else
  modport master(output Play, Step, InputAck, InputReq, HaltReq,
                 input CpuEn, InputLatch, Running, Waiting, Halted, InstrCount);
  modport slave(input Play, Step, InputAck, InputReq, HaltReq,
                output CpuEn, InputLatch, Running, Waiting, Halted, InstrCount);
`endif
endinterface

// File: rtl/exec_controller_edge_sync.sv
// edge_sync: SYNC_DEPTH-flop synchronizer; EDGE=1 turns the output into a rising-edge strobe
module edge_sync
  import exec_ctrl_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);
  logic [SYNC_DEPTH-1:0] sync;
  logic prev;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], d};
      prev <= sync[SYNC_DEPTH-1];
    end
  // Strobe is combinational so the consumer's register adds the only further cycle
  assign q = EDGE ? sync[SYNC_DEPTH-1] & ~prev : sync[SYNC_DEPTH-1];
endmodule

// File: rtl/exec_controller.sv
// exec_controller: sole source of the core's one-instruction enable (run/step/input wait/halt)
// Define EXEC_CTRL_BREAKPOINT_EN to stop free-run when Pc reaches BpAddr
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter logic [31:0] DIVISOR = DIVISOR_DEFAULT
) (
  input logic Clk,
  input logic Reset,
  exec_controller_if.slave bus
);
  localparam logic [31:0] LAST = DIVISOR - 32'd1;
  exec_state_t state, nxt;
  logic [31:0] div, div_n, count;
  logic play, step, ack, pend, pend_n, en_n, latch_n, slot, bp;
  edge_sync #(.EDGE(1'b0)) u_play (.Clk(Clk), .Reset(Reset), .d(bus.Play), .q(play));
  edge_sync #(.EDGE(1'b1)) u_step (.Clk(Clk), .Reset(Reset), .d(bus.Step), .q(step));
  edge_sync #(.EDGE(1'b1)) u_ack (.Clk(Clk), .Reset(Reset), .d(bus.InputAck), .q(ack));
`ifdef EXEC_CTRL_BREAKPOINT_EN
  assign bp = bus.Pc == bus.BpAddr;
`else
  assign bp = 1'b0;
`endif
  assign slot = div == LAST;
  always_comb begin
    nxt = state;
    div_n = 32'd0;
    pend_n = 1'b0;
    en_n = 1'b0;
    latch_n = 1'b0;
    case (state)
      IDLE: nxt = play ? RUN : step ? STEP : IDLE;
      RUN: begin
        nxt = !play ? IDLE : !slot ? RUN : bp ? IDLE : bus.InputReq ? WAIT_INPUT : RUN;
        div_n = (play && !slot) ? div + 32'd1 : 32'd0;
        en_n = play && slot && !bp && !bus.InputReq;
      end
      STEP: begin
        nxt = bus.InputReq ? WAIT_INPUT : IDLE;
        en_n = !bus.InputReq;
      end
      // pend marks the cycle after the latch pulse, when the input instruction issues
      WAIT_INPUT: begin
        nxt = pend ? (play ? RUN : IDLE) : WAIT_INPUT;
        en_n = pend;
        latch_n = ack && !pend;
        pend_n = ack && !pend;
      end
      HALTED: nxt = HALTED;
      default: nxt = IDLE;
    endcase
    if (bus.HaltReq) begin
      nxt = HALTED;
      div_n = 32'd0;
      pend_n = 1'b0;
      en_n = 1'b0;
      latch_n = 1'b0;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      div <= 32'd0;
      pend <= 1'b0;
      count <= 32'd0;
      bus.CpuEn <= 1'b0;
      bus.InputLatch <= 1'b0;
      bus.Running <= 1'b0;
      bus.Waiting <= 1'b0;
      bus.Halted <= 1'b0;
    end else begin
      state <= nxt;
      div <= div_n;
      pend <= pend_n;
      if (en_n && count != 32'hFFFF_FFFF) count <= count + 32'd1;
      bus.CpuEn <= en_n;
      bus.InputLatch <= latch_n;
      bus.Running <= nxt == RUN;
      bus.Waiting <= nxt == WAIT_INPUT;
      bus.Halted <= nxt == HALTED;
    end
  assign bus.InstrCount = count;
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: vector table, directed corner sequences and random run/step traffic
// checked against a pulse-timing model; EXEC_CTRL_BREAKPOINT_EN adds the breakpoint sequence
module tb_exec_controller;
  localparam int D = 4;
  logic Clk = 1'b0, Reset = 1'b1;
  int cyc = 0, n_checks = 0, n_fail = 0, run_cnt = 0;
  int got[$], exp_q[$];
  exec_controller_if bus();
  exec_controller #(.DIVISOR(32'(D))) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (!Reset) begin
    if (bus.CpuEn) got.push_back(cyc);
    if (bus.Running) run_cnt++;
  end
`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic [31:0] pc;
  always @(posedge Clk or posedge Reset)
    if (Reset) pc <= 32'h0040_0000;
    else if (bus.CpuEn) pc <= pc + 32'd4;
  assign bus.Pc = pc;
  initial bus.BpAddr = 32'hFFFF_FFF0;
`endif

  typedef struct {
    logic play, step, ireq, halt;
    int cycles, pulses;
    logic run, wt, hlt;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    bus.Play = 1'b0; bus.Step = 1'b0; bus.InputAck = 1'b0;
    bus.InputReq = 1'b0; bus.HaltReq = 1'b0;
    tick(2);
    Reset = 1'b0;
    got.delete();
    exp_q.delete();
    run_cnt = 0;
  endtask

  task automatic cmp_pulses(input string name);
    chk({name, " pulse count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({name, " pulse cycle"}, 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, " CpuEn"}, 32'(bus.CpuEn), 0);
    chk({name, " InputLatch"}, 32'(bus.InputLatch), 0);
    chk({name, " Running"}, 32'(bus.Running), 0);
    chk({name, " Waiting"}, 32'(bus.Waiting), 0);
    chk({name, " Halted"}, 32'(bus.Halted), 0);
    chk({name, " InstrCount"}, bus.InstrCount, 0);
  endtask

  initial begin
    int k;
    bus.Play = 1'b0; bus.Step = 1'b0; bus.InputAck = 1'b0;
    bus.InputReq = 1'b0; bus.HaltReq = 1'b0;
    #1;
    check_idle_outputs("reset");

    // play, step, ireq, halt, cycles, pulses, Running, Waiting, Halted
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 15, 3, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 15, 3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 15, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 10, 0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 6, 0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.Play = vecs[i].play; bus.Step = vecs[i].step;
      bus.InputReq = vecs[i].ireq; bus.HaltReq = vecs[i].halt;
      tick(vecs[i].cycles);
      chk($sformatf("vec%0d Running", i), 32'(bus.Running), 32'(vecs[i].run));
      chk($sformatf("vec%0d Waiting", i), 32'(bus.Waiting), 32'(vecs[i].wt));
      chk($sformatf("vec%0d Halted", i), 32'(bus.Halted), 32'(vecs[i].hlt));
      chk($sformatf("vec%0d InstrCount", i), bus.InstrCount, 32'(vecs[i].pulses));
      #1;
      chk($sformatf("vec%0d pulses", i), 32'(got.size()), 32'(vecs[i].pulses));
    end

    // free run: first pulse 3+D after Play, then every D
    do_reset();
    k = cyc;
    bus.Play = 1'b1;
    for (int j = 1; j <= 5; j++) exp_q.push_back(k + 3 + D * j);
    tick(24);
    #1;
    cmp_pulses("run");
    chk("run InstrCount", bus.InstrCount, 5);

    // three single steps, 10 cycles apart
    do_reset();
    for (int i = 0; i < 3; i++) begin
      k = cyc;
      exp_q.push_back(k + 4);
      bus.Step = 1'b1;
      tick(2);
      bus.Step = 1'b0;
      tick(8);
    end
    #1;
    cmp_pulses("step");
    chk("step Running cycles", 32'(run_cnt), 0);
    chk("step InstrCount", bus.InstrCount, 3);

    // input wait: Step/Play edges ignored, ack -> latch after 3, CpuEn one later
    do_reset();
    bus.Play = 1'b1; bus.InputReq = 1'b1;
    tick(8);
    chk("wait Waiting", 32'(bus.Waiting), 1);
    chk("wait Running", 32'(bus.Running), 0);
    bus.Step = 1'b1; bus.Play = 1'b0;
    tick(3);
    bus.Step = 1'b0; bus.Play = 1'b1;
    tick(6);
    chk("wait held", 32'(bus.Waiting), 1);
    #1;
    chk("wait no CpuEn", 32'(got.size()), 0);
    bus.InputAck = 1'b1;
    tick(2);
    chk("ack early latch", 32'(bus.InputLatch), 0);
    tick(1);
    chk("ack InputLatch", 32'(bus.InputLatch), 1);
    chk("ack CpuEn early", 32'(bus.CpuEn), 0);
    bus.InputReq = 1'b0;
    tick(1);
    chk("ack latch width", 32'(bus.InputLatch), 0);
    chk("ack CpuEn", 32'(bus.CpuEn), 1);
    chk("ack Running", 32'(bus.Running), 1);
    chk("ack Waiting", 32'(bus.Waiting), 0);
    bus.InputAck = 1'b0;
    tick(1);
    chk("ack CpuEn width", 32'(bus.CpuEn), 0);
    chk("ack InstrCount", bus.InstrCount, 1);

    // halt while waiting is sticky until reset
    do_reset();
    bus.Play = 1'b1; bus.InputReq = 1'b1;
    tick(8);
    chk("halt pre Waiting", 32'(bus.Waiting), 1);
    bus.HaltReq = 1'b1;
    tick(1);
    chk("halt Halted", 32'(bus.Halted), 1);
    chk("halt Waiting", 32'(bus.Waiting), 0);
    bus.HaltReq = 1'b0; bus.InputReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Play = i[0]; bus.Step = ~i[0]; bus.InputAck = i[0];
      tick(6);
    end
    chk("halt sticky", 32'(bus.Halted), 1);
    #1;
    chk("halt no CpuEn", 32'(got.size()), 0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_idle_outputs("async reset");
    bus.Play = 1'b0; bus.Step = 1'b0; bus.InputAck = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(3);
    chk("post reset Halted", 32'(bus.Halted), 0);

    // InstrCount saturation
    do_reset();
    tick(2);
    force dut.count = 32'hFFFF_FFFE;
    tick(1);
    release dut.count;
    tick(1);
    chk("sat preload", bus.InstrCount, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      bus.Step = 1'b1;
      tick(2);
      bus.Step = 1'b0;
      tick(5);
    end
    #1;
    chk("sat pulses", 32'(got.size()), 3);
    chk("sat InstrCount", bus.InstrCount, 32'hFFFF_FFFF);

`ifdef EXEC_CTRL_BREAKPOINT_EN
    do_reset();
    bus.BpAddr = 32'h0040_0008;
    k = cyc;
    bus.Play = 1'b1;
    tick(13);
    bus.Play = 1'b0;
    tick(2);
    chk("bp Running", 32'(bus.Running), 0);
    chk("bp CpuEn", 32'(bus.CpuEn), 0);
    #1;
    chk("bp pulses", 32'(got.size()), 2);
    tick(4);
    k = cyc;
    bus.Step = 1'b1;
    tick(2);
    bus.Step = 1'b0;
    tick(4);
    #1;
    chk("bp step pulses", 32'(got.size()), 3);
    if (got.size() == 3) chk("bp step cycle", 32'(got[2]), 32'(k + 4));
    chk("bp pc", bus.Pc, 32'h0040_000C);
    bus.BpAddr = 32'hFFFF_FFF0;
`endif

    // random mix of run bursts and steps, pulses predicted from pin timing
    do_reset();
    repeat (14) begin
      int h, len;
      k = cyc;
      if ($urandom_range(0, 1) == 1) begin
        h = $urandom_range(1, 3);
        exp_q.push_back(k + 4);
        bus.Step = 1'b1;
        tick(h);
        bus.Step = 1'b0;
        tick($urandom_range(4, 8));
      end else begin
        len = $urandom_range(4, 20);
        for (int e = k + 3 + D; e <= k + len + 2; e += D) exp_q.push_back(e);
        bus.Play = 1'b1;
        tick(len);
        bus.Play = 1'b0;
        tick($urandom_range(6, 10));
      end
    end
    tick(4);
    #1;
    cmp_pulses("random");
    chk("random InstrCount", bus.InstrCount, 32'(exp_q.size()));
    chk("random Running", 32'(bus.Running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
